aq_axis_pattern_gen: RTL and testbench
======================================

# aq_axis_pattern_gen

AXI4-Stream master that emits a configurable burst of packets carrying an incrementing data pattern, with TLAST on the final beat of each packet. It is the transmit-side stimulus source for the slave port of the AXI-Stream FIFO in lab and bring-up builds. The consuming side checks the data against the same seed-plus-index rule. Single clock domain; the FIFO provides any clock crossing.

## Interface
Parameters:
- DATA_WIDTH, 32, width of M_AXIS_TDATA and SEED
- LEN_WIDTH, 16, width of PKT_LEN and the beat-in-packet counter
- CNT_WIDTH, 16, width of PKT_COUNT and the packet counter

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset; asynchronous, active-high
- START  in  1  one-cycle request; sampled only in IDLE
- PKT_LEN  in  LEN_WIDTH  beats per packet; latched at START
- PKT_COUNT  in  CNT_WIDTH  packets per run; latched at START
- GAP  in  8  idle cycles between packets; latched at START
- SEED  in  DATA_WIDTH  data value of the first beat; latched at START
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse at end of run
- M_AXIS_TVALID  out  1  beat valid
- M_AXIS_TREADY  in  1  sink ready
- M_AXIS_TDATA  out  DATA_WIDTH  pattern data
- M_AXIS_TLAST  out  1  last beat of packet
- BEAT_TOTAL  out  32  beats accepted since reset; wraps

## Operation
- States:
  - IDLE: no run in progress.
  - SEND: TVALID=1, presenting the current beat.
  - GAPW: TVALID=0, counting inter-packet idle cycles.
- IDLE → SEND on START when PKT_LEN≠0 and PKT_COUNT≠0. BUSY=1 next cycle.
- START in IDLE with PKT_LEN=0 or PKT_COUNT=0:
  - no beats are sent;
  - DONE pulses on the next cycle;
  - the block stays in IDLE.
- START outside IDLE is ignored. Latched configuration is unaffected by input changes during a run.
- Beat data = SEED + global beat index within the run, modulo 2^DATA_WIDTH. The index does not restart per packet.
- TLAST=1 exactly on beat PKT_LEN−1 of each packet.
- Transfer occurs on a rising edge with TVALID&&TREADY.
- On a transfer of the last beat of a packet:
  - more packets remain, GAP=0: stay in SEND.
  - more packets remain, GAP≠0: go to GAPW for GAP cycles, then back to SEND.
  - last packet: go to IDLE; DONE=1 and BUSY=0 on the following cycle.
- BEAT_TOTAL increments on every transfer and is not cleared by START.

## Timing
- Reset values: TVALID=0, TDATA=0, TLAST=0, BUSY=0, DONE=0, BEAT_TOTAL=0. State is IDLE and all counters are 0.
- Reset asserted mid-run drops TVALID and all state immediately, asynchronously. This is the only case where TVALID falls without a handshake.
- All outputs are registered; there is no combinational path from TREADY to any output.
- START at edge N → TVALID=1, TDATA=SEED at N+1.
- Throughput with TREADY held high and GAP=0: one beat per cycle, including across packet boundaries.
- While TVALID=1 and TREADY=0, TDATA and TLAST hold stable; TVALID is never withdrawn.
- Final transfer at edge M → TVALID=0 and DONE=1 during cycle M+1. DONE lasts exactly one cycle. A START in that cycle is accepted (state is IDLE).
- Inter-packet gap: exactly GAP cycles with TVALID=0 between the last-beat transfer and the next TVALID=1.
- Counters compare against the latched value minus one; there is no overflow at PKT_LEN = 2^LEN_WIDTH−1.
- TDATA wraps from all-ones to 0 silently.

## Structure
- Shared package aq_axis_pkg holds:
  - the state typedef (IDLE, SEND, GAPW);
  - the default widths AQ_AXIS_DATA_W=32 and AQ_AXIS_LEN_W=16, also used by the FIFO benches.
- Single module, no sub-module. The implementation needs the beat, packet and gap counters plus a data accumulator.

## Test plan
- SEED=0x100, PKT_LEN=20, PKT_COUNT=1, GAP=0, TREADY=1:
  - beats 0x100..0x113 on 20 consecutive cycles;
  - TLAST only on 0x113;
  - DONE one cycle later; BEAT_TOTAL=20.
- PKT_LEN=4, PKT_COUNT=3, GAP=2, TREADY=1:
  - data 0..11, TLAST on 3, 7 and 11;
  - exactly 2 TVALID=0 cycles between packets.
- TREADY toggled pseudo-randomly (50%) with PKT_LEN=16:
  - TDATA/TLAST stable while stalled, TVALID never drops;
  - 16 beats arrive in order.
- PKT_LEN=0 or PKT_COUNT=0 with START:
  - no TVALID;
  - DONE one cycle after START, BUSY stays 0.
- SEED=0xFFFFFFFE, PKT_LEN=4: data FFFFFFFE, FFFFFFFF, 0, 1.
- RST pulsed during beat 5 of 10 with TREADY=0:
  - TVALID=0 and BUSY=0 immediately;
  - a new START then begins again from SEED.

Source files
------------

// File: rtl/aq_axis_pkg.sv
// Shared state type and default widths for the AQ AXI-Stream blocks.
package aq_axis_pkg;

  localparam int AQ_AXIS_DATA_W = 32;
  localparam int AQ_AXIS_LEN_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAPW
  } aq_axis_state_e;

endpackage

// File: rtl/aq_axis_pattern_gen.sv
// AXI4-Stream master emitting bursts of packets with seed+index data.
module aq_axis_pattern_gen
  import aq_axis_pkg::*;
#(
  parameter int DATA_WIDTH = AQ_AXIS_DATA_W,
  parameter int LEN_WIDTH  = AQ_AXIS_LEN_W,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [LEN_WIDTH-1:0]  PKT_LEN,
  input  logic [CNT_WIDTH-1:0]  PKT_COUNT,
  input  logic [7:0]            GAP,
  input  logic [DATA_WIDTH-1:0] SEED,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [31:0]           BEAT_TOTAL
);

  aq_axis_state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]  len_m1_q, len_m1_d;
  logic [CNT_WIDTH-1:0]  cnt_m1_q, cnt_m1_d;
  logic [7:0]            gap_q, gap_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
  logic [7:0]            gcnt_q, gcnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [31:0]           total_q, total_d;

  logic xfer;
  logic beat_last;
  logic pkt_last;
  logic cfg_ok;

  assign xfer      = tvalid_q & M_AXIS_TREADY;
  assign beat_last = (beat_q == len_m1_q);
  assign pkt_last  = (pkt_q == cnt_m1_q);
  assign cfg_ok    = (PKT_LEN != '0) && (PKT_COUNT != '0);

  always_comb begin
    state_d  = state_q;
    len_m1_d = len_m1_q;
    cnt_m1_d = cnt_m1_q;
    gap_d    = gap_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    gcnt_d   = gcnt_q;
    data_d   = data_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    total_d  = total_q;

    unique case (state_q)
      IDLE: begin
        if (START && !cfg_ok) begin
          done_d = 1'b1;
        end else if (START) begin
          len_m1_d = PKT_LEN - LEN_WIDTH'(1);
          cnt_m1_d = PKT_COUNT - CNT_WIDTH'(1);
          gap_d    = GAP;
          beat_d   = '0;
          pkt_d    = '0;
          gcnt_d   = '0;
          data_d   = SEED;
          tvalid_d = 1'b1;
          tlast_d  = (PKT_LEN == LEN_WIDTH'(1));
          busy_d   = 1'b1;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (xfer) begin
          total_d = total_q + 32'd1;
          data_d  = data_q + DATA_WIDTH'(1);
          if (!beat_last) begin
            beat_d  = beat_q + LEN_WIDTH'(1);
            tlast_d = ((beat_q + LEN_WIDTH'(1)) == len_m1_q);
          end else if (pkt_last) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            beat_d  = '0;
            pkt_d   = pkt_q + CNT_WIDTH'(1);
            tlast_d = (len_m1_q == '0);
            // A non-zero gap parks TVALID low until the gap expires
            if (gap_q != 8'd0) begin
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              gcnt_d   = '0;
              state_d  = GAPW;
            end
          end
        end
      end

      GAPW: begin
        if (gcnt_q == gap_q - 8'd1) begin
          tvalid_d = 1'b1;
          tlast_d  = (len_m1_q == '0);
          state_d  = SEND;
        end else begin
          gcnt_d = gcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      len_m1_q <= '0;
      cnt_m1_q <= '0;
      gap_q    <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      gcnt_q   <= '0;
      data_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_m1_q <= len_m1_d;
      cnt_m1_q <= cnt_m1_d;
      gap_q    <= gap_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      gcnt_q   <= gcnt_d;
      data_q   <= data_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      total_q  <= total_d;
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = data_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign BEAT_TOTAL    = total_q;

endmodule

// File: tb/tb_aq_axis_pattern_gen.sv
// Directed bench for aq_axis_pattern_gen.
module tb_aq_axis_pattern_gen;

  logic        ACLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] PKT_LEN;
  logic [15:0] PKT_COUNT;
  logic [7:0]  GAP;
  logic [31:0] SEED;
  logic        BUSY;
  logic        DONE;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic [31:0] BEAT_TOTAL;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_total = '0;

  always #5 ACLK = ~ACLK;

  aq_axis_pattern_gen dut (
    .ACLK          (ACLK),
    .RST           (RST),
    .START         (START),
    .PKT_LEN       (PKT_LEN),
    .PKT_COUNT     (PKT_COUNT),
    .GAP           (GAP),
    .SEED          (SEED),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .BEAT_TOTAL    (BEAT_TOTAL)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_run(input logic [31:0] seed,
                           input logic [15:0] len,
                           input logic [15:0] cnt,
                           input logic [7:0]  gap);
    SEED      = seed;
    PKT_LEN   = len;
    PKT_COUNT = cnt;
    GAP       = gap;
    START     = 1'b1;
    tick();
    START     = 1'b0;
    SEED      = 32'hDEAD_BEEF;
    PKT_LEN   = 16'd7;
    PKT_COUNT = 16'd9;
    GAP       = 8'd5;
  endtask

  task automatic run(input logic [31:0] seed,
                     input int len, input int cnt,
                     input int gap, input bit rnd,
                     input string nm);
    int          beats;
    int          cyc;
    int          gapc;
    bit          pend;
    bit          stall;
    bit          rdy;
    logic [31:0] pd;
    logic        pl;
    logic [31:0] ed;
    beats = 0;
    cyc   = 0;
    gapc  = 0;
    pend  = 1'b0;
    stall = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    start_run(seed, 16'(len), 16'(cnt), 8'(gap));
    chk({nm, "_first_valid"}, 64'(M_AXIS_TVALID), 1);
    while (DONE !== 1'b1 && cyc < 4000) begin
      START = (cyc == 3);
      chk({nm, "_busy"}, 64'(BUSY), 1);
      if (stall) begin
        chk({nm, "_stall_valid"}, 64'(M_AXIS_TVALID), 1);
        chk({nm, "_stall_data"}, 64'(M_AXIS_TDATA), 64'(pd));
        chk({nm, "_stall_last"}, 64'(M_AXIS_TLAST), 64'(pl));
      end
      if (pend) begin
        if (!M_AXIS_TVALID) begin
          gapc++;
        end else begin
          chk({nm, "_gap"}, 64'(gapc), 64'(gap));
          pend = 1'b0;
        end
      end
      if (M_AXIS_TVALID) begin
        ed = seed + 32'(beats);
        chk({nm, "_data"}, 64'(M_AXIS_TDATA), 64'(ed));
        chk({nm, "_last"}, 64'(M_AXIS_TLAST),
            64'((beats % len) == len - 1));
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      M_AXIS_TREADY = rdy;
      stall = M_AXIS_TVALID && !rdy;
      pd = M_AXIS_TDATA;
      pl = M_AXIS_TLAST;
      if (M_AXIS_TVALID && rdy) begin
        if ((beats % len) == len - 1 && beats < len * cnt - 1) begin
          pend = 1'b1;
          gapc = 0;
        end
        beats++;
      end
      tick();
      cyc++;
    end
    START = 1'b0;
    M_AXIS_TREADY = 1'b1;
    chk({nm, "_done"}, 64'(DONE), 1);
    chk({nm, "_end_valid"}, 64'(M_AXIS_TVALID), 0);
    chk({nm, "_end_busy"}, 64'(BUSY), 0);
    chk({nm, "_beats"}, 64'(beats), 64'(len * cnt));
    if (!rnd) begin
      chk({nm, "_cycles"}, 64'(cyc), 64'(len * cnt + (cnt - 1) * gap));
    end
    exp_total = exp_total + 32'(beats);
    chk({nm, "_total"}, 64'(BEAT_TOTAL), 64'(exp_total));
  endtask

  initial begin
    RST           = 1'b1;
    START         = 1'b0;
    PKT_LEN       = '0;
    PKT_COUNT     = '0;
    GAP           = '0;
    SEED          = '0;
    M_AXIS_TREADY = 1'b0;
    #12;
    chk("rst_valid", 64'(M_AXIS_TVALID), 0);
    chk("rst_data", 64'(M_AXIS_TDATA), 0);
    chk("rst_last", 64'(M_AXIS_TLAST), 0);
    chk("rst_busy", 64'(BUSY), 0);
    chk("rst_done", 64'(DONE), 0);
    chk("rst_total", 64'(BEAT_TOTAL), 0);
    RST = 1'b0;
    tick();
    M_AXIS_TREADY = 1'b1;

    run(32'h100, 20, 1, 0, 1'b0, "single");
    tick();
    chk("single_done_drop", 64'(DONE), 0);
    chk("single_idle_valid", 64'(M_AXIS_TVALID), 0);

    run(32'h0, 4, 3, 2, 1'b0, "gap2");
    run(32'h2000, 16, 1, 0, 1'b1, "stall");
    tick();
    run(32'h40, 3, 4, 0, 1'b1, "b2b_rnd");
    run(32'h80, 1, 3, 1, 1'b0, "len1");
    tick();

    start_run(32'h55, 16'd0, 16'd3, 8'd0);
    chk("len0_done", 64'(DONE), 1);
    chk("len0_valid", 64'(M_AXIS_TVALID), 0);
    chk("len0_busy", 64'(BUSY), 0);
    tick();
    chk("len0_done_drop", 64'(DONE), 0);
    chk("len0_valid2", 64'(M_AXIS_TVALID), 0);
    chk("len0_busy2", 64'(BUSY), 0);

    start_run(32'h55, 16'd5, 16'd0, 8'd0);
    chk("cnt0_done", 64'(DONE), 1);
    chk("cnt0_valid", 64'(M_AXIS_TVALID), 0);
    chk("cnt0_busy", 64'(BUSY), 0);
    tick();
    chk("cnt0_done_drop", 64'(DONE), 0);
    chk("cnt0_total", 64'(BEAT_TOTAL), 64'(exp_total));

    run(32'hFFFF_FFFE, 4, 1, 0, 1'b0, "wrap");
    tick();

    start_run(32'h500, 16'd10, 16'd1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("rstrun_data", 64'(M_AXIS_TDATA), 64'(32'h500 + i));
      tick();
    end
    M_AXIS_TREADY = 1'b0;
    chk("rstrun_beat5", 64'(M_AXIS_TDATA), 64'h505);
    tick();
    chk("rstrun_hold_valid", 64'(M_AXIS_TVALID), 1);
    chk("rstrun_hold_data", 64'(M_AXIS_TDATA), 64'h505);
    #2;
    RST = 1'b1;
    #1;
    chk("rstmid_valid", 64'(M_AXIS_TVALID), 0);
    chk("rstmid_busy", 64'(BUSY), 0);
    chk("rstmid_total", 64'(BEAT_TOTAL), 0);
    #1;
    RST = 1'b0;
    tick();
    M_AXIS_TREADY = 1'b1;
    exp_total = '0;
    run(32'h500, 10, 1, 0, 1'b0, "rerun");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
